// File: rtl/xbee_tx_arbiter.sv
// Four-client round-robin arbiter that packs a 16-bit request into a 4-byte XBee
// frame (header, payload hi/lo, XOR checksum) and paces bytes to the serial rate.
module xbee_tx_arbiter #(
  parameter int CLKFREQ  = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic [7:0]  frame_count
);

  localparam longint BYTE_CYCLES_L =
    (longint'(GAP_BITS) * longint'(CLKFREQ)) / longint'(BAUD);
  localparam int BYTE_CYCLES = int'(BYTE_CYCLES_L);
  localparam int CNT_W       = $clog2(BYTE_CYCLES);
  // The SEND cycle plus the terminal zero cycle of WAIT make up the other two.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BYTE_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      payload_q, payload_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [3:0]       ack_q, ack_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic             busy_q, busy_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             cool_q, cool_d;

  logic [1:0] cand;
  logic [1:0] pick_id;
  logic       pick_valid;
  logic [7:0] hdr_byte, chk_byte, cur_byte;

  // Round-robin search: start just past the previous winner and wrap upward.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cand       = '0;
    pick_id    = last_grant_q;
    pick_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    hdr_byte = {6'b101000, grant_id_q};
    chk_byte = hdr_byte ^ payload_q[15:8] ^ payload_q[7:0];
    cur_byte = hdr_byte;
    unique case (idx_q)
      2'd0: cur_byte = hdr_byte;
      2'd1: cur_byte = payload_q[15:8];
      2'd2: cur_byte = payload_q[7:0];
      2'd3: cur_byte = chk_byte;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    payload_d     = payload_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    ack_d         = '0;
    tx_data_d     = tx_data_q;
    tx_send_d     = 1'b0;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    cool_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // cool_q holds IDLE for one extra cycle after a frame so the inter-frame
        // gap is at least a full byte slot plus two cycles.
        if (enable && pick_valid && !cool_q) begin
          grant_id_d         = pick_id;
          payload_d          = req_data[{pick_id, 4'b0000} +: 16];
          ack_d[pick_id]     = 1'b1;
          busy_d             = 1'b1;
          idx_d              = 2'd0;
          state_d            = S_SEND;
        end
      end

      S_SEND: begin
        tx_data_d = cur_byte;
        tx_send_d = 1'b1;
        cnt_d     = GAP_LOAD;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end else begin
            last_grant_d  = grant_id_q;
            frame_count_d = frame_count_q + 8'd1;
            busy_d        = 1'b0;
            cool_d        = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      payload_q     <= 16'h0000;
      last_grant_q  <= 2'd3;
      grant_id_q    <= 2'd3;
      ack_q         <= 4'b0000;
      tx_data_q     <= 8'h00;
      tx_send_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 8'h00;
      cool_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      payload_q     <= payload_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      ack_q         <= ack_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      cool_q        <= cool_d;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_xbee_tx_arbiter.sv
// Bench for xbee_tx_arbiter: a slow instance at 110-cycle byte slots and a fast
// instance at 2-cycle slots for the frame counter wrap.
`timescale 1ns/1ps
module tb_xbee_tx_arbiter;

  localparam int CLKFREQ  = 96000;
  localparam int BAUD     = 9600;
  localparam int GAP_BITS = 11;
  localparam int C        = GAP_BITS * CLKFREQ / BAUD;    // 110
  localparam int F_BAUD   = 528000;
  localparam int FC       = GAP_BITS * CLKFREQ / F_BAUD;  // 2

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_send, busy;
  logic [1:0]  grant_id;
  logic [7:0]  frame_count;

  logic        f_enable;
  logic [3:0]  f_req;
  logic [63:0] f_req_data;
  logic [3:0]  f_ack;
  logic [7:0]  f_tx_data;
  logic        f_tx_send, f_busy;
  logic [1:0]  f_grant_id;
  logic [7:0]  f_frame_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] m_last;
  int         m_fc;
  int         f_cyc_q[$];
  logic [7:0] f_dat_q[$];

  xbee_tx_arbiter #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
    .ack(ack), .tx_data(tx_data), .tx_send(tx_send), .busy(busy),
    .grant_id(grant_id), .frame_count(frame_count));

  xbee_tx_arbiter #(.CLKFREQ(CLKFREQ), .BAUD(F_BAUD), .GAP_BITS(GAP_BITS)) u_fast (
    .clk(clk), .reset(reset), .enable(f_enable), .req(f_req), .req_data(f_req_data),
    .ack(f_ack), .tx_data(f_tx_data), .tx_send(f_tx_send), .busy(f_busy),
    .grant_id(f_grant_id), .frame_count(f_frame_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (f_tx_send === 1'b1) begin
      f_cyc_q.push_back(cyc);
      f_dat_q.push_back(f_tx_data);
    end
  end

  // Reference model: round-robin pick and frame contents from the protocol rules.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    end
    return last;
  endfunction

  function automatic logic [31:0] frame_bytes(input logic [1:0] id, input logic [15:0] p);
    logic [7:0] b0;
    b0 = 8'hA0 | {6'b000000, id};
    return {b0, p[15:8], p[7:0], b0 ^ p[15:8] ^ p[7:0]};
  endfunction

  // Waits for an ack, then gathers the four byte pulses of that frame.
  // mode: 0 hold req, 1 drop granted bit, 2 scramble inputs, 3 drop + payload to all ones.
  task automatic collect_frame(input int mode, output bit to, output int ack_wait,
                               output logic [3:0] ack_v, output logic [3:0] ack_nx,
                               output int lat, output logic [31:0] bytes,
                               output int first_c, output int last_c, output int sp_bad);
    int n, np, prev, a_c;
    to = 1'b0; ack_wait = 0; ack_v = '0; ack_nx = '0; lat = 0; bytes = '0;
    first_c = 0; last_c = 0; sp_bad = 0; prev = 0; np = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack === 4'b0000 && n < 4 * C + 100);
    ack_wait = n;
    if (ack === 4'b0000) begin
      to = 1'b1;
      return;
    end
    ack_v = ack;
    a_c   = cyc;
    if (mode == 1 || mode == 3) req = req & ~ack;
    if (mode == 3) req_data = {64{1'b1}};
    if (mode == 2) begin
      req_data = {$urandom, $urandom};
      req      = 4'($urandom);
      enable   = 1'($urandom);
    end
    n = 0;
    while (np < 4 && n < 4 * C + 50) begin
      @(negedge clk);
      n++;
      if (n == 1) ack_nx = ack;
      if (tx_send === 1'b1) begin
        bytes = {bytes[23:0], tx_data};
        if (np == 0) begin
          first_c = cyc;
          lat     = cyc - a_c;
        end else if (cyc - prev != C) begin
          sp_bad++;
        end
        prev = cyc;
        np++;
      end
    end
    last_c = prev;
    if (np < 4) to = 1'b1;
  endtask

  // From the negedge of a B3 pulse: samples busy one cycle before and at the end of the slot.
  task automatic wait_gap(output logic busy_mid, output logic busy_end, output logic [7:0] fc);
    repeat (C - 2) @(negedge clk);
    busy_mid = busy;
    @(negedge clk);
    busy_end = busy;
    fc       = frame_count;
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 4 * C + 50) begin
      @(negedge clk);
      n++;
    end
    to = (busy !== 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = 4'b0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last = 2'd3;
    m_fc   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 4'b1111; req_data = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    total++; if (tx_send !== 1'b0) begin bad++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    m_last = 2'd3;
    m_fc   = 0;
  endtask

  task automatic test_single();
    bit to; int aw, lat, fc0, lc, spb; logic [3:0] av, anx; logic [31:0] by;
    logic bm, be; logic [7:0] fcv; logic [1:0] g;
    req_data = {$urandom, $urandom};
    req_data[15:0] = 16'h1234;
    req = 4'b0001; enable = 1'b1;
    g = rr_pick(m_last, 4'b0001);
    collect_frame(1, to, aw, av, anx, lat, by, fc0, lc, spb);
    total++; if (to) begin bad++; $display("FAIL single_timeout: frame not seen"); end
    total++; if (aw !== 1) begin bad++; $display("FAIL single_ack_latency: got %0d want 1", aw); end
    total++; if (av !== 4'b0001 << g) begin bad++; $display("FAIL single_ack: got %b want %b", av, 4'b0001 << g); end
    total++; if (anx !== 4'b0000) begin bad++; $display("FAIL single_ack_width: got %b want 0000", anx); end
    total++; if (lat !== 1) begin bad++; $display("FAIL single_send_latency: got %0d want 1", lat); end
    total++; if (by !== frame_bytes(g, 16'h1234)) begin bad++; $display("FAIL single_bytes: got %h want %h", by, frame_bytes(g, 16'h1234)); end
    total++; if (spb !== 0) begin bad++; $display("FAIL single_spacing: %0d gaps not %0d", spb, C); end
    total++; if (grant_id !== g) begin bad++; $display("FAIL single_grant_id: got %0d want %0d", grant_id, g); end
    wait_gap(bm, be, fcv);
    m_last = g; m_fc = (m_fc + 1) % 256;
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL single_busy_mid: got %b want 1", bm); end
    total++; if (be !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", be); end
    total++; if (fcv !== 8'(m_fc)) begin bad++; $display("FAIL single_frame_count: got %0d want %0d", fcv, m_fc); end
  endtask

  task automatic test_round_robin();
    bit to; int aw, lat, fc0, lc, spb, prev_last; logic [3:0] av, anx; logic [31:0] by, e;
    logic [1:0] g;
    do_reset();
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req = 4'b1111; enable = 1'b1;
    prev_last = 0;
    for (int f = 0; f < 5; f++) begin
      g = rr_pick(m_last, req);
      e = frame_bytes(g, req_data[16 * g +: 16]);
      collect_frame(0, to, aw, av, anx, lat, by, fc0, lc, spb);
      total++; if (to) begin bad++; $display("FAIL rr_timeout: frame %0d not seen", f); end
      total++; if (av !== 4'b0001 << g) begin bad++; $display("FAIL rr_ack: frame %0d got %b want %b", f, av, 4'b0001 << g); end
      total++; if (by !== e) begin bad++; $display("FAIL rr_bytes: frame %0d got %h want %h", f, by, e); end
      total++; if (spb !== 0) begin bad++; $display("FAIL rr_spacing: frame %0d %0d bad gaps", f, spb); end
      if (f > 0) begin
        total++;
        if (fc0 - prev_last < C + 2) begin
          bad++; $display("FAIL rr_frame_gap: got %0d want >= %0d", fc0 - prev_last, C + 2);
        end
      end
      prev_last = lc;
      m_last = g; m_fc = (m_fc + 1) % 256;
    end
    req = 4'b0000;
    wait_idle(to);
    total++; if (to) begin bad++; $display("FAIL rr_idle_timeout: busy stuck"); end
    total++; if (frame_count !== 8'(m_fc)) begin bad++; $display("FAIL rr_frame_count: got %0d want %0d", frame_count, m_fc); end
  endtask

  task automatic test_enable();
    bit to; int aw, lat, fc0, lc, spb, na, ns; logic [3:0] av, anx; logic [31:0] by, e;
    enable = 1'b0; req = 4'b0100; req_data = {$urandom, $urandom};
    na = 0; ns = 0;
    repeat (500) begin
      @(negedge clk);
      if (ack !== 4'b0000) na++;
      if (tx_send !== 1'b0) ns++;
    end
    total++; if (na !== 0) begin bad++; $display("FAIL enable_low_ack: got %0d acks want 0", na); end
    total++; if (ns !== 0) begin bad++; $display("FAIL enable_low_send: got %0d sends want 0", ns); end
    e = frame_bytes(2'd2, req_data[47:32]);
    enable = 1'b1;
    collect_frame(1, to, aw, av, anx, lat, by, fc0, lc, spb);
    total++; if (to) begin bad++; $display("FAIL enable_timeout: frame not seen"); end
    total++; if (aw !== 1) begin bad++; $display("FAIL enable_ack_latency: got %0d want 1", aw); end
    total++; if (av !== 4'b0100) begin bad++; $display("FAIL enable_ack: got %b want 0100", av); end
    total++; if (by !== e) begin bad++; $display("FAIL enable_bytes: got %h want %h", by, e); end
    m_last = 2'd2; m_fc = (m_fc + 1) % 256;
  endtask

  task automatic test_latch();
    bit to; int aw, lat, fc0, lc, spb; logic [3:0] av, anx; logic [31:0] by, e;
    logic [15:0] p; logic [1:0] g;
    p = 16'($urandom);
    req_data = {$urandom, $urandom};
    req_data[63:48] = p;
    req = 4'b1000; enable = 1'b1;
    g = rr_pick(m_last, 4'b1000);
    e = frame_bytes(g, p);
    collect_frame(3, to, aw, av, anx, lat, by, fc0, lc, spb);
    total++; if (to) begin bad++; $display("FAIL latch_timeout: frame not seen"); end
    total++; if (by !== e) begin bad++; $display("FAIL latch_bytes: got %h want %h", by, e); end
    m_last = g; m_fc = (m_fc + 1) % 256;
  endtask

  task automatic test_random();
    bit to; int aw, lat, fc0, lc, spb; logic [3:0] av, anx, r; logic [31:0] by, e;
    logic [63:0] d; logic bm, be; logic [7:0] fcv; logic [1:0] g;
    for (int it = 0; it < 8; it++) begin
      r = 4'($urandom_range(1, 15));
      d = {$urandom, $urandom};
      req = r; req_data = d; enable = 1'b1;
      g = rr_pick(m_last, r);
      e = frame_bytes(g, d[16 * g +: 16]);
      collect_frame(2, to, aw, av, anx, lat, by, fc0, lc, spb);
      total++; if (to) begin bad++; $display("FAIL rand_timeout: iter %0d", it); end
      total++; if (av !== 4'b0001 << g) begin bad++; $display("FAIL rand_ack: iter %0d req %b got %b want %b", it, r, av, 4'b0001 << g); end
      total++; if (by !== e) begin bad++; $display("FAIL rand_bytes: iter %0d got %h want %h", it, by, e); end
      total++; if (spb !== 0 || lat !== 1) begin bad++; $display("FAIL rand_timing: iter %0d bad gaps %0d latency %0d", it, spb, lat); end
      wait_gap(bm, be, fcv);
      m_last = g; m_fc = (m_fc + 1) % 256;
      total++; if (fcv !== 8'(m_fc) || be !== 1'b0) begin bad++; $display("FAIL rand_frame_end: iter %0d count %0d busy %b want %0d 0", it, fcv, be, m_fc); end
      req = 4'b0000; enable = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    bit to; int aw, lat, fc0, lc, spb, n, ns, na; logic [3:0] av, anx; logic [31:0] by, e;
    logic [63:0] d; logic bm, be; logic [7:0] fcv;
    do_reset();
    req_data = {$urandom, $urandom}; req = 4'b0001; enable = 1'b1;
    n = 0; ns = 0;
    while (ns < 2 && n < 4 * C) begin
      @(negedge clk);
      n++;
      if (ack !== 4'b0000) req = 4'b0000;
      if (tx_send === 1'b1) ns++;
    end
    total++; if (ns !== 2) begin bad++; $display("FAIL mid_setup: got %0d sends want 2", ns); end
    reset = 1'b1; req = 4'b1010;
    d = {$urandom, $urandom}; req_data = d;
    na = 0; ns = 0;
    repeat (3 * C) begin
      @(negedge clk);
      if (ack !== 4'b0000) na++;
      if (tx_send !== 1'b0) ns++;
    end
    total++; if (ns !== 0) begin bad++; $display("FAIL mid_sends: got %0d want 0", ns); end
    total++; if (na !== 0) begin bad++; $display("FAIL mid_reset_ack: got %0d want 0", na); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (frame_count !== 8'h00) begin bad++; $display("FAIL mid_frame_count: got %0d want 0", frame_count); end
    reset = 1'b0; m_last = 2'd3; m_fc = 0;
    e = frame_bytes(rr_pick(m_last, 4'b1010), d[31:16]);
    collect_frame(1, to, aw, av, anx, lat, by, fc0, lc, spb);
    total++; if (to) begin bad++; $display("FAIL mid_timeout: frame not seen"); end
    total++; if (aw !== 1 || av !== 4'b0010) begin bad++; $display("FAIL mid_first_grant: ack %b after %0d want 0010 after 1", av, aw); end
    total++; if (by !== e) begin bad++; $display("FAIL mid_bytes: got %h want %h", by, e); end
    wait_gap(bm, be, fcv);
    m_last = 2'd1; m_fc = 1;
    total++; if (fcv !== 8'(m_fc)) begin bad++; $display("FAIL mid_count_after: got %0d want %0d", fcv, m_fc); end
    wait_idle(to);
  endtask

  task automatic test_wrap();
    int n, fc_bad, sp_bad, dat_bad, gap;
    bit to;
    logic [31:0] e;
    f_cyc_q.delete(); f_dat_q.delete();
    f_req_data = {16'h0000, 16'hBEEF, 32'h0}; f_req = 4'b0100; f_enable = 1'b1;
    e = frame_bytes(2'd2, 16'hBEEF);
    fc_bad = 0; to = 1'b0;
    for (int k = 0; k < 256; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (f_ack === 4'b0000 && n < 40);
      if (f_ack === 4'b0000) begin
        to = 1'b1;
        break;
      end
      if (f_frame_count !== 8'(k)) fc_bad++;
      if (k == 255) f_req = 4'b0000;
    end
    f_req = 4'b0000;
    total++; if (to) begin bad++; $display("FAIL wrap_timeout: ack missing"); end
    n = 0;
    while (f_busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    total++; if (f_frame_count !== 8'h00) begin bad++; $display("FAIL wrap_count: got %0d want 0", f_frame_count); end
    total++; if (fc_bad !== 0) begin bad++; $display("FAIL wrap_running_count: %0d frames saw wrong count", fc_bad); end
    total++; if (f_cyc_q.size() !== 1024) begin bad++; $display("FAIL wrap_pulses: got %0d want 1024", f_cyc_q.size()); end
    sp_bad = 0; dat_bad = 0;
    for (int i = 0; i < f_cyc_q.size(); i++) begin
      if (f_dat_q[i] !== e[31 - 8 * (i % 4) -: 8]) dat_bad++;
      if (i > 0) begin
        gap = f_cyc_q[i] - f_cyc_q[i - 1];
        if ((i % 4 == 0) ? (gap < FC + 2) : (gap != FC)) sp_bad++;
      end
    end
    total++; if (sp_bad !== 0) begin bad++; $display("FAIL wrap_spacing: %0d bad gaps", sp_bad); end
    total++; if (dat_bad !== 0) begin bad++; $display("FAIL wrap_data: %0d bad bytes", dat_bad); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; req = 4'b0000; req_data = '0;
    f_enable = 1'b1; f_req = 4'b0000; f_req_data = '0;
    m_last = 2'd3; m_fc = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_enable();
    test_latch();
    test_random();
    test_reset_midframe();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
